// File: rtl/forward_update_source_pkg.sv
// Shared hash-table definitions: forward-record field layout and hold-counter width.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package forward_update_source_pkg;

    // Hold counters are 4 bits wide, so HOLD_CYCLES is limited to 1..15.
    localparam int HOLD_CNT_W = 4;
    typedef logic [HOLD_CNT_W-1:0] hold_cnt_t;

    // Forward-record layout, LSB first:
    //   shift_valid | shift_adr | valid | data | key | hash_adr
    function automatic int fwd_rec_w(input int aw, input int kw, input int dw, input int sw);
        return aw + kw + dw + sw + 2;
    endfunction

    function automatic int fwd_off_shift_valid();
        return 0;
    endfunction

    function automatic int fwd_off_shift_adr();
        return 1;
    endfunction

    function automatic int fwd_off_valid(input int sw);
        return sw + 1;
    endfunction

    function automatic int fwd_off_data(input int sw);
        return sw + 2;
    endfunction

    function automatic int fwd_off_key(input int sw, input int dw);
        return sw + dw + 2;
    endfunction

    function automatic int fwd_off_adr(input int sw, input int dw, input int kw);
        return sw + dw + kw + 2;
    endfunction

endpackage

// File: rtl/forward_update_source_hold_counter.sv
// Saturating hold counter: reloads HOLD_CYCLES on load, otherwise counts down to 0.
// Latency: o_active rises one enabled edge after i_load.
// Backpressure: none; a load always wins over the decrement (newest request restarts the hold).
module hold_counter
    import forward_update_source_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clk_en,
    input  logic i_load,
    output logic o_active
);

    localparam hold_cnt_t HOLD_LOAD = hold_cnt_t'(HOLD_CYCLES);
    localparam hold_cnt_t CNT_ONE   = hold_cnt_t'(1);

    hold_cnt_t r_cnt;

    // Reload on load, else decrement while nonzero; 0 is sticky so the counter never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clk_en) begin
            if (i_load) begin
                r_cnt <= HOLD_LOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    assign o_active = (r_cnt != '0);

endmodule

// File: rtl/forward_update_source.sv
// Registers own-memory entry writes and next-memory valid updates and forwards them for HOLD_CYCLES.
// Latency: 1 enabled cycle from request to mem_we_o / forward flags.
// Backpressure: none; every request on an enabled edge is accepted, clk_en=0 freezes everything.
module forward_update_source
    import forward_update_source_pkg::*;
#(
    parameter int DATA_WIDTH           = 4,
    parameter int KEY_WIDTH            = 2,
    parameter int HASH_ADR_WIDTH       = 2,
    parameter int SHIFT_HASH_ADR_WIDTH = 2,
    parameter int HOLD_CYCLES          = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clk_en,
    input  logic                            wr_req_i,
    input  logic [HASH_ADR_WIDTH-1:0]       wr_hash_adr_i,
    input  logic [KEY_WIDTH-1:0]            wr_key_i,
    input  logic [DATA_WIDTH-1:0]           wr_data_i,
    input  logic                            wr_valid_i,
    input  logic [SHIFT_HASH_ADR_WIDTH-1:0] wr_shift_hash_adr_i,
    input  logic                            wr_shift_valid_i,
    input  logic                            nm_req_i,
    input  logic [SHIFT_HASH_ADR_WIDTH-1:0] nm_hash_adr_i,
    input  logic                            nm_valid_i,
    output logic                            mem_we_o,
    output logic [HASH_ADR_WIDTH-1:0]       mem_adr_o,
    output logic [KEY_WIDTH-1:0]            mem_key_o,
    output logic [DATA_WIDTH-1:0]           mem_data_o,
    output logic                            mem_valid_o,
    output logic [SHIFT_HASH_ADR_WIDTH-1:0] mem_shift_adr_o,
    output logic                            mem_shift_valid_o,
    output logic [HASH_ADR_WIDTH-1:0]       forward_hash_adr_o,
    output logic [KEY_WIDTH-1:0]            forward_key_o,
    output logic [DATA_WIDTH-1:0]           forward_data_o,
    output logic                            forward_valid_o,
    output logic [SHIFT_HASH_ADR_WIDTH-1:0] forward_shift_hash_adr_o,
    output logic                            forward_shift_valid_o,
    output logic                            forward_updated_mem_o,
    output logic [SHIFT_HASH_ADR_WIDTH-1:0] forward_next_mem_hash_adr_o,
    output logic                            forward_next_mem_valid_o,
    output logic                            forward_next_mem_updated_o
);

    localparam int AW = HASH_ADR_WIDTH;
    localparam int KW = KEY_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = SHIFT_HASH_ADR_WIDTH;

    localparam int REC_W     = fwd_rec_w(AW, KW, DW, SW);
    localparam int OFF_SVLD  = fwd_off_shift_valid();
    localparam int OFF_SADR  = fwd_off_shift_adr();
    localparam int OFF_VLD   = fwd_off_valid(SW);
    localparam int OFF_DATA  = fwd_off_data(SW);
    localparam int OFF_KEY   = fwd_off_key(SW, DW);
    localparam int OFF_ADR   = fwd_off_adr(SW, DW, KW);

    logic [REC_W-1:0] w_wr_rec;
    logic [REC_W-1:0] r_wr_rec;
    logic             r_mem_we;
    logic [SW-1:0]    r_nm_adr;
    logic             r_nm_valid;
    logic             w_own_active;
    logic             w_nm_active;

    // Pack the incoming entry into the shared forward-record layout.
    always_comb begin
        w_wr_rec                       = '0;
        w_wr_rec[OFF_SVLD]             = wr_shift_valid_i;
        w_wr_rec[OFF_SADR +: SW]       = wr_shift_hash_adr_i;
        w_wr_rec[OFF_VLD]              = wr_valid_i;
        w_wr_rec[OFF_DATA +: DW]       = wr_data_i;
        w_wr_rec[OFF_KEY +: KW]        = wr_key_i;
        w_wr_rec[OFF_ADR +: AW]        = wr_hash_adr_i;
    end

    // Write strobe and accepted entry. The memory port and the forward record load on the
    // same edge, clear on the same reset and hold otherwise, so one record register feeds both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_we <= 1'b0;
            r_wr_rec <= '0;
        end else if (clk_en) begin
            r_mem_we <= wr_req_i;
            if (wr_req_i) begin
                r_wr_rec <= w_wr_rec;
            end
        end
    end

    // Last next-memory valid-bit update; independent of the own-memory channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nm_adr   <= '0;
            r_nm_valid <= 1'b0;
        end else if (clk_en && nm_req_i) begin
            r_nm_adr   <= nm_hash_adr_i;
            r_nm_valid <= nm_valid_i;
        end
    end

    hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_own_hold (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_clk_en (clk_en),
        .i_load   (wr_req_i),
        .o_active (w_own_active)
    );

    hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_nm_hold (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_clk_en (clk_en),
        .i_load   (nm_req_i),
        .o_active (w_nm_active)
    );

    assign mem_we_o                    = r_mem_we;
    assign mem_adr_o                   = r_wr_rec[OFF_ADR +: AW];
    assign mem_key_o                   = r_wr_rec[OFF_KEY +: KW];
    assign mem_data_o                  = r_wr_rec[OFF_DATA +: DW];
    assign mem_valid_o                 = r_wr_rec[OFF_VLD];
    assign mem_shift_adr_o             = r_wr_rec[OFF_SADR +: SW];
    assign mem_shift_valid_o           = r_wr_rec[OFF_SVLD];

    assign forward_hash_adr_o          = r_wr_rec[OFF_ADR +: AW];
    assign forward_key_o               = r_wr_rec[OFF_KEY +: KW];
    assign forward_data_o              = r_wr_rec[OFF_DATA +: DW];
    assign forward_valid_o             = r_wr_rec[OFF_VLD];
    assign forward_shift_hash_adr_o    = r_wr_rec[OFF_SADR +: SW];
    assign forward_shift_valid_o       = r_wr_rec[OFF_SVLD];
    assign forward_updated_mem_o       = w_own_active;

    assign forward_next_mem_hash_adr_o = r_nm_adr;
    assign forward_next_mem_valid_o    = r_nm_valid;
    assign forward_next_mem_updated_o  = w_nm_active;

endmodule

// File: tb/tb_forward_update_source.sv
// Bench for forward_update_source: directed scenarios plus a random run against a cycle model.
// Latency: expected outputs are queued before each edge and checked on the following falling edge.
// Backpressure: none in the DUT; the bench drives one stimulus vector per clock.
module tb_forward_update_source;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_en;
    logic       wr_req;
    logic [1:0] wr_adr, wr_key, wr_sadr;
    logic [3:0] wr_data;
    logic       wr_valid, wr_svalid;
    logic       nm_req;
    logic [1:0] nm_adr;
    logic       nm_valid;

    logic       mem_we, mem_valid, mem_svalid, f_valid, f_svalid, f_upd, f_nvalid, f_nupd;
    logic [1:0] mem_adr, mem_key, mem_sadr, f_adr, f_key, f_sadr, f_nadr;
    logic [3:0] mem_data, f_data;

    logic       d1_we, d1_valid, d1_svalid, d1_fvalid, d1_fsvalid, d1_upd, d1_nvalid, d1_nupd;
    logic [1:0] d1_adr, d1_key, d1_sadr, d1_fadr, d1_fkey, d1_fsadr, d1_nadr;
    logic [3:0] d1_data, d1_fdata;

    typedef struct packed {
        logic       we;
        logic [1:0] madr;
        logic [1:0] mkey;
        logic [3:0] mdata;
        logic       mval;
        logic [1:0] msadr;
        logic       msval;
        logic [1:0] fadr;
        logic [1:0] fkey;
        logic [3:0] fdata;
        logic       fval;
        logic [1:0] fsadr;
        logic       fsval;
        logic       upd;
        logic [1:0] nadr;
        logic       nval;
        logic       nupd;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic       m_we;
    logic [1:0] m_adr, m_key, m_sadr, m_nadr;
    logic [3:0] m_data;
    logic       m_valid, m_svalid, m_nvalid;
    int         m_cnt, m_ncnt;

    always #5 clk = ~clk;

    forward_update_source #(.HOLD_CYCLES(HOLD)) u_dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .wr_req_i(wr_req), .wr_hash_adr_i(wr_adr), .wr_key_i(wr_key), .wr_data_i(wr_data),
        .wr_valid_i(wr_valid), .wr_shift_hash_adr_i(wr_sadr), .wr_shift_valid_i(wr_svalid),
        .nm_req_i(nm_req), .nm_hash_adr_i(nm_adr), .nm_valid_i(nm_valid),
        .mem_we_o(mem_we), .mem_adr_o(mem_adr), .mem_key_o(mem_key), .mem_data_o(mem_data),
        .mem_valid_o(mem_valid), .mem_shift_adr_o(mem_sadr), .mem_shift_valid_o(mem_svalid),
        .forward_hash_adr_o(f_adr), .forward_key_o(f_key), .forward_data_o(f_data),
        .forward_valid_o(f_valid), .forward_shift_hash_adr_o(f_sadr),
        .forward_shift_valid_o(f_svalid), .forward_updated_mem_o(f_upd),
        .forward_next_mem_hash_adr_o(f_nadr), .forward_next_mem_valid_o(f_nvalid),
        .forward_next_mem_updated_o(f_nupd)
    );

    forward_update_source #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .wr_req_i(wr_req), .wr_hash_adr_i(wr_adr), .wr_key_i(wr_key), .wr_data_i(wr_data),
        .wr_valid_i(wr_valid), .wr_shift_hash_adr_i(wr_sadr), .wr_shift_valid_i(wr_svalid),
        .nm_req_i(nm_req), .nm_hash_adr_i(nm_adr), .nm_valid_i(nm_valid),
        .mem_we_o(d1_we), .mem_adr_o(d1_adr), .mem_key_o(d1_key), .mem_data_o(d1_data),
        .mem_valid_o(d1_valid), .mem_shift_adr_o(d1_sadr), .mem_shift_valid_o(d1_svalid),
        .forward_hash_adr_o(d1_fadr), .forward_key_o(d1_fkey), .forward_data_o(d1_fdata),
        .forward_valid_o(d1_fvalid), .forward_shift_hash_adr_o(d1_fsadr),
        .forward_shift_valid_o(d1_fsvalid), .forward_updated_mem_o(d1_upd),
        .forward_next_mem_hash_adr_o(d1_nadr), .forward_next_mem_valid_o(d1_nvalid),
        .forward_next_mem_updated_o(d1_nupd)
    );

    obs_t obs;
    assign obs = '{we: mem_we, madr: mem_adr, mkey: mem_key, mdata: mem_data, mval: mem_valid,
                   msadr: mem_sadr, msval: mem_svalid, fadr: f_adr, fkey: f_key, fdata: f_data,
                   fval: f_valid, fsadr: f_sadr, fsval: f_svalid, upd: f_upd, nadr: f_nadr,
                   nval: f_nvalid, nupd: f_nupd};

    // Scoreboard consumer: one expected entry per driven clock, checked on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL scoreboard t=%0t got=%h want=%h", $time, obs, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_we = 0; m_adr = 0; m_key = 0; m_sadr = 0; m_nadr = 0; m_data = 0;
        m_valid = 0; m_svalid = 0; m_nvalid = 0; m_cnt = 0; m_ncnt = 0;
    endtask

    // Drive one clock of stimulus, queue the model's expected outputs, advance past the edge.
    task automatic step(input logic en, input logic wr, input logic [1:0] a, input logic [1:0] k,
                        input logic [3:0] d, input logic v, input logic [1:0] sa, input logic sv,
                        input logic nm, input logic [1:0] na, input logic nv);
        obs_t e;
        clk_en = en; wr_req = wr; wr_adr = a; wr_key = k; wr_data = d; wr_valid = v;
        wr_sadr = sa; wr_svalid = sv; nm_req = nm; nm_adr = na; nm_valid = nv;
        if (en) begin
            m_we = wr;
            if (wr) begin
                m_adr = a; m_key = k; m_data = d; m_valid = v; m_sadr = sa; m_svalid = sv;
                m_cnt = HOLD;
            end else if (m_cnt > 0) m_cnt--;
            if (nm) begin
                m_nadr = na; m_nvalid = nv; m_ncnt = HOLD;
            end else if (m_ncnt > 0) m_ncnt--;
        end
        e = '{we: m_we, madr: m_adr, mkey: m_key, mdata: m_data, mval: m_valid, msadr: m_sadr,
              msval: m_svalid, fadr: m_adr, fkey: m_key, fdata: m_data, fval: m_valid,
              fsadr: m_sadr, fsval: m_svalid, upd: (m_cnt != 0), nadr: m_nadr, nval: m_nvalid,
              nupd: (m_ncnt != 0)};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic en);
        step(en, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 0;
        model_reset();
        clk_en = 1; wr_req = 1; wr_adr = 3; wr_key = 3; wr_data = 4'hf; wr_valid = 1;
        wr_sadr = 3; wr_svalid = 1; nm_req = 1; nm_adr = 3; nm_valid = 1;
        #1;
        total++; if (obs !== '0) begin bad++; $display("FAIL reset_initial got=%h want=0", obs); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (obs !== '0) begin bad++; $display("FAIL reset_clocked got=%h want=0", obs); end
        @(negedge clk);
        reset = 1;
        #1;
    endtask

    task automatic test_single_write();
        step(1, 1, 2, 1, 9, 1, 1, 0, 0, 0, 0);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b want=1", mem_we); end
        total++; if (mem_adr !== 2'd2) begin bad++; $display("FAIL single_adr got=%0d want=2", mem_adr); end
        total++; if (f_data !== 4'd9) begin bad++; $display("FAIL single_fdata got=%0d want=9", f_data); end
        total++; if (f_upd !== 1'b1) begin bad++; $display("FAIL single_upd1 got=%b want=1", f_upd); end
        idle(1);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_we_drop got=%b want=0", mem_we); end
        total++; if (f_upd !== 1'b1) begin bad++; $display("FAIL single_upd2 got=%b want=1", f_upd); end
        idle(1);
        total++; if (f_upd !== 1'b0) begin bad++; $display("FAIL single_upd3 got=%b want=0", f_upd); end
        total++; if (f_adr !== 2'd2) begin bad++; $display("FAIL single_retain got=%0d want=2", f_adr); end
    endtask

    task automatic test_back_to_back();
        step(1, 1, 1, 2, 5, 1, 0, 1, 0, 0, 0);
        total++; if (f_adr !== 2'd1) begin bad++; $display("FAIL b2b_adr1 got=%0d want=1", f_adr); end
        step(1, 1, 3, 0, 6, 0, 2, 0, 0, 0, 0);
        total++; if (f_adr !== 2'd3) begin bad++; $display("FAIL b2b_adr3 got=%0d want=3", f_adr); end
        total++; if (f_upd !== 1'b1) begin bad++; $display("FAIL b2b_upd2 got=%b want=1", f_upd); end
        idle(1);
        total++; if (f_upd !== 1'b1) begin bad++; $display("FAIL b2b_upd3 got=%b want=1", f_upd); end
        idle(1);
        total++; if (f_upd !== 1'b0) begin bad++; $display("FAIL b2b_upd4 got=%b want=0", f_upd); end
    endtask

    task automatic test_clk_en_freeze();
        step(1, 1, 0, 3, 12, 1, 3, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1);
            total++;
            if (mem_we !== 1'b1 || f_upd !== 1'b1 || f_nupd !== 1'b0 || mem_adr !== 2'd0) begin
                bad++;
                $display("FAIL freeze_%0d got=we%b upd%b nupd%b adr%0d want=we1 upd1 nupd0 adr0",
                         i, mem_we, f_upd, f_nupd, mem_adr);
            end
        end
        idle(1);
        total++; if (mem_we !== 1'b0 || f_upd !== 1'b1) begin bad++; $display("FAIL freeze_resume got=we%b upd%b want=we0 upd1", mem_we, f_upd); end
        idle(1);
        total++; if (f_upd !== 1'b0) begin bad++; $display("FAIL freeze_end got=%b want=0", f_upd); end
    endtask

    task automatic test_dual_channel();
        step(1, 1, 2, 2, 7, 1, 1, 1, 1, 3, 0);
        total++; if (f_upd !== 1'b1 || f_nupd !== 1'b1) begin bad++; $display("FAIL dual_flags got=%b%b want=11", f_upd, f_nupd); end
        total++; if (f_nadr !== 2'd3 || f_nvalid !== 1'b0) begin bad++; $display("FAIL dual_nm got=adr%0d v%b want=adr3 v0", f_nadr, f_nvalid); end
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1);
        total++; if (f_upd !== 1'b1 || f_nupd !== 1'b1 || f_nadr !== 2'd2) begin bad++; $display("FAIL dual_nm2 got=%b%b adr%0d want=11 adr2", f_upd, f_nupd, f_nadr); end
        idle(1);
        total++; if (f_upd !== 1'b0 || f_nupd !== 1'b1) begin bad++; $display("FAIL dual_indep got=%b%b want=01", f_upd, f_nupd); end
        idle(1);
        total++; if (f_nupd !== 1'b0 || f_nvalid !== 1'b1) begin bad++; $display("FAIL dual_nm_end got=upd%b v%b want=upd0 v1", f_nupd, f_nvalid); end
    endtask

    task automatic test_reset_mid_hold();
        step(1, 1, 3, 3, 15, 1, 2, 1, 1, 1, 1);
        @(negedge clk);
        #2;
        reset = 0;
        model_reset();
        #1;
        total++; if (obs !== '0) begin bad++; $display("FAIL midreset_async got=%h want=0", obs); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (obs !== '0) begin bad++; $display("FAIL midreset_held got=%h want=0", obs); end
        @(negedge clk);
        reset = 1;
        #1;
        step(1, 1, 1, 2, 4, 0, 3, 1, 0, 0, 0);
        total++; if (mem_we !== 1'b1 || mem_adr !== 2'd1 || f_upd !== 1'b1) begin bad++; $display("FAIL release_first got=we%b adr%0d upd%b want=we1 adr1 upd1", mem_we, mem_adr, f_upd); end
        idle(1);
        idle(1);
    endtask

    task automatic test_hold_one();
        logic [3:0] seen;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) step(1, 1, 2'(i), 1, 4'(i), 1, 0, 0, 0, 0, 0);
            else            idle(1);
            seen[3-i] = d1_upd;
        end
        total++; if (seen !== 4'b1010) begin bad++; $display("FAIL hold_one_toggle got=%b want=1010", seen); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 2'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 2'($urandom),
                 1'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom), 1'($urandom));
        end
        idle(1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_clk_en_freeze();
        test_dual_channel();
        test_reset_mid_hold();
        test_hold_one();
        test_random();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
